// File: rtl/pulse_rep_core.sv
// pulse_rep_core: captures one AXI-stream pulse into block RAM and replays it R times.
// Define PULSE_REP_TUSER_EN to latch the first-beat tuser and replay it on every output beat.
module pulse_rep_core #(
  parameter int unsigned MAX_PULSE_SIZE = 8192,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TUSER_WIDTH    = 128
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [31:0]            pulse_size,
  input  logic [31:0]            num_rep,
  output logic [31:0]            rep_count,
  output logic                   busy,
  input  logic [WIDTH-1:0]       i_tdata,
  input  logic [TUSER_WIDTH-1:0] i_tuser,
  input  logic                   i_tvalid,
  input  logic                   i_tlast,
  output logic                   i_tready,
  output logic [WIDTH-1:0]       o_tdata,
  output logic [TUSER_WIDTH-1:0] o_tuser,
  output logic                   o_tvalid,
  output logic                   o_tlast,
  input  logic                   o_tready
);

  localparam int unsigned AW   = $clog2(MAX_PULSE_SIZE);
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] MAXL = MAX_PULSE_SIZE[AW:0];

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [AW:0]      wr_addr_q, wr_addr_d;
  logic [AW:0]      len_q, len_d;
  logic [31:0]      rep_q, rep_d;
  logic [31:0]      rep_count_q, rep_count_d;
  logic [AW:0]      rd_addr_q, rd_addr_d;
  logic [31:0]      iss_pass_q, iss_pass_d;
  logic             rd_vld_q, rd_vld_d;
  logic             rd_last_q, rd_last_d;
  logic [1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [WIDTH-1:0] f_data_q [2];
  logic [WIDTH-1:0] f_data_d [2];
  logic             f_last_q [2];
  logic             f_last_d [2];

  logic [WIDTH-1:0] mem [MAX_PULSE_SIZE];
  logic [WIDTH-1:0] ram_rdata;

  logic        hs_in, first_beat, in_end;
  logic [AW:0] len_clamp, eff_len;
  logic        head_is_rd, o_valid_int, head_last, pop, push, last_rd, issue;

  always_comb begin
    hs_in      = (state_q == ST_LOAD) && rdy_q && i_tvalid && !clear;
    first_beat = (wr_addr_q == '0);
    if (pulse_size == 32'd0)              len_clamp = ONE;
    else if (pulse_size > MAX_PULSE_SIZE) len_clamp = MAXL;
    else                                  len_clamp = pulse_size[AW:0];
    eff_len = first_beat ? len_clamp : len_q;
    in_end  = hs_in && (i_tlast || ((wr_addr_q + ONE) == eff_len));

    // Output order is skid entries (oldest first) then the RAM read register;
    // when the skid is empty the RAM register drives the port directly.
    head_is_rd  = (fifo_cnt_q == 2'd0);
    o_valid_int = !head_is_rd || rd_vld_q;
    head_last   = head_is_rd ? rd_last_q : f_last_q[0];
    pop         = o_valid_int && o_tready;
    push        = rd_vld_q && !(head_is_rd && pop);

    f_data_d   = f_data_q;
    f_last_d   = f_last_q;
    fifo_cnt_d = fifo_cnt_q;
    if (pop && !head_is_rd) begin
      f_data_d[0] = f_data_q[1];
      f_last_d[0] = f_last_q[1];
      fifo_cnt_d  = fifo_cnt_q - 2'd1;
    end
    if (push) begin
      if (fifo_cnt_d == 2'd0) begin
        f_data_d[0] = ram_rdata;
        f_last_d[0] = rd_last_q;
      end else begin
        f_data_d[1] = ram_rdata;
        f_last_d[1] = rd_last_q;
      end
      fifo_cnt_d = fifo_cnt_d + 2'd1;
    end

    // A new read is issued only if the skid can still absorb it unpopped next cycle.
    last_rd = (rd_addr_q == (len_q - ONE));
    issue   = (state_q == ST_PLAY) && !clear && (iss_pass_q != rep_q) && (fifo_cnt_d <= 2'd1);

    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    len_d       = len_q;
    rep_d       = rep_q;
    rep_count_d = rep_count_q;
    rd_addr_d   = rd_addr_q;
    iss_pass_d  = iss_pass_q;
    rd_vld_d    = issue;
    rd_last_d   = issue && last_rd;

    if (issue) begin
      rd_addr_d = last_rd ? '0 : (rd_addr_q + ONE);
      if (last_rd) iss_pass_d = iss_pass_q + 32'd1;
    end

    if (hs_in) begin
      if (first_beat) begin
        len_d = len_clamp;
        rep_d = (num_rep == 32'd0) ? 32'd1 : num_rep;
      end
      if (in_end) begin
        state_d     = ST_PLAY;
        wr_addr_d   = '0;
        len_d       = wr_addr_q + ONE;
        rep_count_d = '0;
        rd_addr_d   = '0;
        iss_pass_d  = '0;
      end else begin
        wr_addr_d = wr_addr_q + ONE;
      end
    end

    if (pop && head_last) begin
      rep_count_d = rep_count_q + 32'd1;
      if ((rep_count_q + 32'd1) == rep_q) state_d = ST_LOAD;
    end

    if (clear) begin
      state_d     = ST_LOAD;
      wr_addr_d   = '0;
      rd_addr_d   = '0;
      iss_pass_d  = '0;
      rep_count_d = '0;
      rd_vld_d    = 1'b0;
      rd_last_d   = 1'b0;
      fifo_cnt_d  = '0;
    end

    rdy_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LOAD;
      rdy_q       <= 1'b0;
      wr_addr_q   <= '0;
      len_q       <= ONE;
      rep_q       <= 32'd1;
      rep_count_q <= '0;
      rd_addr_q   <= '0;
      iss_pass_q  <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      fifo_cnt_q  <= '0;
      f_data_q    <= '{default: '0};
      f_last_q    <= '{default: 1'b0};
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      wr_addr_q   <= wr_addr_d;
      len_q       <= len_d;
      rep_q       <= rep_d;
      rep_count_q <= rep_count_d;
      rd_addr_q   <= rd_addr_d;
      iss_pass_q  <= iss_pass_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      fifo_cnt_q  <= fifo_cnt_d;
      f_data_q    <= f_data_d;
      f_last_q    <= f_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hs_in) mem[wr_addr_q[AW-1:0]] <= i_tdata;
    if (issue) ram_rdata <= mem[rd_addr_q[AW-1:0]];
  end

`ifdef PULSE_REP_TUSER_EN
  logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;

  always_comb begin
    tuser_d = tuser_q;
    if (hs_in && first_beat) tuser_d = i_tuser;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tuser_q <= '0;
    else          tuser_q <= tuser_d;
  end

  assign o_tuser = tuser_q;
`else
  logic unused_tuser;
  assign unused_tuser = ^i_tuser;
  assign o_tuser      = '0;
`endif

  assign o_tvalid  = o_valid_int;
  assign o_tlast   = o_valid_int && head_last;
  assign o_tdata   = !o_valid_int ? '0 : (head_is_rd ? ram_rdata : f_data_q[0]);
  assign i_tready  = rdy_q;
  assign busy      = (state_q == ST_PLAY);
  assign rep_count = rep_count_q;

endmodule

// File: tb/tb_pulse_rep_core.sv
// Self-checking bench for pulse_rep_core: directed pulses plus randomized pulses and
// backpressure, checked against a capture/replay queue model.
module tb_pulse_rep_core;

  localparam int unsigned MAXP = 16;
  localparam int unsigned W    = 32;
  localparam int unsigned TW   = 128;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic [31:0]   pulse_size = '0;
  logic [31:0]   num_rep = '0;
  logic [31:0]   rep_count;
  logic          busy;
  logic [W-1:0]  i_tdata = '0;
  logic [TW-1:0] i_tuser = '0;
  logic          i_tvalid = 1'b0;
  logic          i_tlast = 1'b0;
  logic          i_tready;
  logic [W-1:0]  o_tdata;
  logic [TW-1:0] o_tuser;
  logic          o_tvalid;
  logic          o_tlast;
  logic          o_tready = 1'b0;

  pulse_rep_core #(.MAX_PULSE_SIZE(MAXP), .WIDTH(W), .TUSER_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .pulse_size(pulse_size), .num_rep(num_rep), .rep_count(rep_count), .busy(busy),
    .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic [31:0] in_vals[$];
  logic [31:0] captured[$];
  beat_t       exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bail(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s: observed=timeout expected=progress", tag);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  // ps/nr: settings; tlast_at: beat index carrying i_tlast (-1 none); rdy_pct: o_tready duty;
  // abort_at: output beat number on which to clear (or reset if abort_rst), 0 for none.
  task automatic run_pulse(input int ps, input int nr, input int tlast_at, input int rdy_pct,
                           input int abort_at, input bit abort_rst, input logic [127:0] tu);
    int lclamp, reps, idx, budget, n_in, beats, lasts;
    bit done;
    beat_t e;
    logic [127:0] exp_tu;
`ifdef PULSE_REP_TUSER_EN
    exp_tu = tu;
`else
    exp_tu = '0;
`endif
    lclamp = (ps == 0) ? 1 : ((ps > int'(MAXP)) ? int'(MAXP) : ps);
    reps   = (nr == 0) ? 1 : nr;
    idx = 0; budget = 0; n_in = 0; done = 1'b0; beats = 0; lasts = 0;
    captured.delete();
    exp_q.delete();
    pulse_size = 32'(ps);
    num_rep    = 32'(nr);

    while (!done) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
      end else begin
        i_tvalid = 1'b1;
        i_tdata  = in_vals[idx];
        i_tlast  = (idx == tlast_at);
        i_tuser  = (idx == 0) ? tu : {$urandom, $urandom, $urandom, $urandom};
        if (i_tready) begin
          captured.push_back(in_vals[idx]);
          if (idx == tlast_at || idx + 1 == lclamp) begin
            done = 1'b1;
            n_in = cyc;
          end
          idx++;
        end
      end
      budget++;
      if (budget > 200) bail("feed_timeout");
    end

    for (int r = 0; r < reps; r++)
      for (int k = 0; k < captured.size(); k++) begin
        e.d = captured[k];
        e.l = (k == captured.size() - 1);
        exp_q.push_back(e);
      end

    budget = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
      o_tready = ($urandom_range(0, 99) < rdy_pct);
      if (cyc == n_in + 1) chk("tvalid_lat1", {127'd0, o_tvalid}, 128'd0);
      if (cyc == n_in + 2) chk("tvalid_lat2", {127'd0, o_tvalid}, 128'd1);
      chk("tready_play", {127'd0, i_tready}, 128'd0);
      chk("busy_play", {127'd0, busy}, 128'd1);
      chk("rep_count_run", {96'd0, rep_count}, 128'(lasts));
      if (o_tvalid) begin
        chk("data", {96'd0, o_tdata}, {96'd0, exp_q[0].d});
        chk("last", {127'd0, o_tlast}, {127'd0, exp_q[0].l});
        chk("tuser", o_tuser, exp_tu);
      end
      if (o_tvalid && o_tready) begin
        e = exp_q.pop_front();
        beats++;
        if (e.l) lasts++;
        if (beats == abort_at) begin
          if (abort_rst) begin
            #2 reset_n = 1'b0;
            #1;
            chk("rst_tvalid", {127'd0, o_tvalid}, 128'd0);
            chk("rst_busy", {127'd0, busy}, 128'd0);
            chk("rst_rep_count", {96'd0, rep_count}, 128'd0);
            chk("rst_tready", {127'd0, i_tready}, 128'd0);
            @(negedge clk);
            reset_n  = 1'b1;
            o_tready = 1'b0;
            @(negedge clk);
            chk("rst_tready_rel", {127'd0, i_tready}, 128'd1);
          end else begin
            clear = 1'b1;
            @(negedge clk);
            clear    = 1'b0;
            o_tready = 1'b0;
            chk("clr_tvalid", {127'd0, o_tvalid}, 128'd0);
            chk("clr_rep_count", {96'd0, rep_count}, 128'd0);
            chk("clr_tready", {127'd0, i_tready}, 128'd1);
            chk("clr_busy", {127'd0, busy}, 128'd0);
          end
          return;
        end
      end
      budget++;
      if (budget > 1000) bail("drain_timeout");
    end

    @(negedge clk);
    o_tready = 1'b0;
    chk("end_tready", {127'd0, i_tready}, 128'd1);
    chk("end_tvalid", {127'd0, o_tvalid}, 128'd0);
    chk("end_rep_count", {96'd0, rep_count}, 128'(reps));
    chk("end_busy", {127'd0, busy}, 128'd0);
  endtask

  task automatic load_vals(input int first, input int n);
    in_vals.delete();
    for (int i = 0; i < n; i++) in_vals.push_back(32'(first + i));
  endtask

  task automatic load_rand(input int n);
    in_vals.delete();
    for (int i = 0; i < n; i++) in_vals.push_back($urandom);
  endtask

  initial begin
    int ps, nr, tl, rp;

    repeat (2) @(negedge clk);
    chk("rst_i_tready", {127'd0, i_tready}, 128'd0);
    chk("rst_o_tvalid", {127'd0, o_tvalid}, 128'd0);
    chk("rst_o_tdata", {96'd0, o_tdata}, 128'd0);
    chk("rst_o_tlast", {127'd0, o_tlast}, 128'd0);
    chk("rst_o_tuser", o_tuser, 128'd0);
    chk("rst_rep_count", {96'd0, rep_count}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_i_tready", {127'd0, i_tready}, 128'd1);

    load_vals(1, 4);
    run_pulse(4, 3, 3, 100, 0, 1'b0, {$urandom, $urandom, $urandom, 16'h0, 16'hABCD});

    load_vals(10, 5);
    run_pulse(8, 2, 4, 100, 0, 1'b0, 128'h1);

    load_vals(7, 1);
    run_pulse(0, 0, -1, 100, 0, 1'b0, 128'h2);

    load_rand(16);
    run_pulse(16, 4, 15, 50, 0, 1'b0, {112'h5A5A, 16'hABCD});

    // Oversized pulse clamps to MAXP; the unused tail forms the next pulse.
    load_rand(20);
    run_pulse(100, 1, -1, 70, 0, 1'b0, 128'h3);
    in_vals = in_vals[MAXP:19];
    run_pulse(6, 2, 3, 80, 0, 1'b0, 128'h4);

    load_vals(40, 5);
    run_pulse(3, 2, -1, 60, 0, 1'b0, 128'h5);

    load_vals(1, 4);
    run_pulse(4, 5, 3, 100, 6, 1'b0, 128'h6);
    in_vals.delete();
    in_vals.push_back(32'd9);
    in_vals.push_back(32'd9);
    run_pulse(2, 1, 1, 100, 0, 1'b0, 128'h7);

    for (int t = 0; t < 6; t++) begin
      load_rand(20);
      ps = $urandom_range(0, 20);
      nr = $urandom_range(0, 3);
      tl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 19)) : -1;
      rp = $urandom_range(30, 100);
      run_pulse(ps, nr, tl, rp, 0, 1'b0, {$urandom, $urandom, $urandom, $urandom});
    end

    load_vals(100, 5);
    run_pulse(5, 3, 4, 100, 3, 1'b1, 128'h8);
    load_rand(8);
    run_pulse(8, 2, 7, 50, 0, 1'b0, 128'h9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
